// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states
// and the step-class select used by the datapath.
package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_e;

    typedef enum logic {
        CLS_MUL = 1'b0,
        CLS_DIV = 1'b1
    } op_class_e;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the core controller (master) and the
// multiply/divide unit (slave).
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             DivByZero;

    modport master (
        output Start, Op, OpA, OpB,
        input  Busy, Done, Hi, Lo, DivByZero
    );

    modport slave (
        input  Start, Op, OpA, OpB,
        output Busy, Done, Hi, Lo, DivByZero
    );
endinterface

// File: rtl/mult_div_unit_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
// Accumulator layout: multiply {0, product[2W-1:0]}; divide {rem[W:0], quo[W-1:0]}.
module mult_div_step
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  op_class_e          i_class,
    input  logic [2*WIDTH:0]   i_acc,
    input  logic [WIDTH-1:0]   i_opnd,
    output logic [2*WIDTH:0]   o_acc
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_upper;
    logic [WIDTH+1:0] w_shifted;
    logic [WIDTH+1:0] w_diff;
    logic [WIDTH:0]   w_rem_next;
    logic             w_qbit;

    // Next accumulator for the selected op class
    always_comb begin
        w_sum      = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_opnd};
        w_upper    = {1'b0, i_acc[2*WIDTH-1:WIDTH]};
        w_shifted  = {i_acc[2*WIDTH:WIDTH], i_acc[WIDTH-1]};
        w_diff     = w_shifted - {2'b00, i_opnd};
        w_rem_next = '0;
        w_qbit     = 1'b0;
        o_acc      = '0;

        case (i_class)
            CLS_MUL: begin
                if (i_acc[0]) begin
                    o_acc = {1'b0, w_sum, i_acc[WIDTH-1:1]};
                end else begin
                    o_acc = {1'b0, w_upper, i_acc[WIDTH-1:1]};
                end
            end
            CLS_DIV: begin
                // A set top bit of the difference is the borrow: restore
                if (w_diff[WIDTH+1]) begin
                    w_rem_next = w_shifted[WIDTH:0];
                    w_qbit     = 1'b0;
                end else begin
                    w_rem_next = w_diff[WIDTH:0];
                    w_qbit     = 1'b1;
                end
                o_acc = {w_rem_next, i_acc[WIDTH-2:0], w_qbit};
            end
            default: begin
                o_acc = i_acc;
            end
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit: IDLE -> CALC (WIDTH steps) -> FIX -> DONE,
// Busy high for WIDTH+2 cycles, {Hi, Lo} written on the FIX->DONE edge.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic           Clk,
    input  logic           Reset,
    mult_div_unit_if.slave bus
);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    op_class_e          r_class;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               r_dbz;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH:0]   r_acc;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_dbz_out;

    logic               w_signed;
    logic               w_is_div;
    logic               w_sign_a;
    logic               w_sign_b;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH:0]   w_acc_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_hi;
    logic [WIDTH-1:0]   w_lo;

    // Operand decode: magnitudes and sign flags for signed ops
    always_comb begin
        w_signed = op_is_signed(bus.Op);
        w_is_div = bus.Op[1];
        w_sign_a = w_signed & bus.OpA[WIDTH-1];
        w_sign_b = w_signed & bus.OpB[WIDTH-1];
        if (w_sign_a) begin
            w_abs_a = -bus.OpA;
        end else begin
            w_abs_a = bus.OpA;
        end
        if (w_sign_b) begin
            w_abs_b = -bus.OpB;
        end else begin
            w_abs_b = bus.OpB;
        end
    end

    mult_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_class (r_class),
        .i_acc   (r_acc),
        .i_opnd  (r_opnd),
        .o_acc   (w_acc_next)
    );

    // Sign fix-up of the raw magnitude result
    always_comb begin
        w_prod = r_acc[2*WIDTH-1:0];
        w_hi   = '0;
        w_lo   = '0;
        if (r_class == CLS_MUL) begin
            if (r_neg_lo) begin
                w_prod = -r_acc[2*WIDTH-1:0];
            end else begin
                w_prod = r_acc[2*WIDTH-1:0];
            end
            w_hi = w_prod[2*WIDTH-1:WIDTH];
            w_lo = w_prod[WIDTH-1:0];
        end else begin
            // With a zero divisor no step borrows, so the remainder is |OpA| and
            // re-applying the dividend sign restores OpA unmodified.
            if (r_neg_hi) begin
                w_hi = -r_acc[2*WIDTH-1:WIDTH];
            end else begin
                w_hi = r_acc[2*WIDTH-1:WIDTH];
            end
            if (r_dbz) begin
                w_lo = '1;
            end else if (r_neg_lo) begin
                w_lo = -r_acc[WIDTH-1:0];
            end else begin
                w_lo = r_acc[WIDTH-1:0];
            end
        end
    end

    // Control FSM, iteration counter and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_class   <= CLS_MUL;
            r_neg_lo  <= 1'b0;
            r_neg_hi  <= 1'b0;
            r_dbz     <= 1'b0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_dbz_out <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.Start) begin
                        r_state  <= CALC;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_class  <= w_is_div ? CLS_DIV : CLS_MUL;
                        r_neg_lo <= w_sign_a ^ w_sign_b;
                        r_neg_hi <= w_sign_a;
                        r_dbz    <= w_is_div && (bus.OpB == '0);
                        r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
                        r_acc    <= {{(WIDTH+1){1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH-1)) begin
                        r_state <= FIX;
                    end else begin
                        r_state <= CALC;
                    end
                end
                FIX: begin
                    r_hi      <= w_hi;
                    r_lo      <= w_lo;
                    r_dbz_out <= r_dbz;
                    r_done    <= 1'b1;
                    r_state   <= DONE;
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.Busy      = r_busy;
    assign bus.Done      = r_done;
    assign bus.Hi        = r_hi;
    assign bus.Lo        = r_lo;
    assign bus.DivByZero = r_dbz_out;

endmodule
